edge_pattern_gen: RTL and testbench
===================================

// Module: edge_pattern_gen
// PURPOSE
//  Edge source that pairs with EdgeDetector: emits a programmable pulse train on sig_out
//  so that the detector sees known rising and falling edges at known cycles.
//  Lab4 benches and board tops drive it with a start/length command. The rise/fall marks
//  serve as reference strobes for checking the detector's outputs cycle by cycle.
// PARAMETERS
//  LEN_W  8  width of the high/low phase lengths, in clock cycles
//  CNT_W  4  width of the pulse-count field
// PORTS
//  Clk        in   1      single system clock; all logic is on its rising edge
//  Rst_n      in   1      synchronous reset, active-low
//  start      in   1      command strobe; accepted only when busy=0
//  abort      in   1      cancel the train in progress
//  high_len   in   LEN_W  cycles sig_out stays 1 per pulse; sampled with start
//  low_len    in   LEN_W  cycles sig_out stays 0 after each pulse; sampled with start
//  pulse_cnt  in   CNT_W  number of pulses; sampled with start
//  sig_out    out  1      generated waveform; this is the detector's input
//  rise_mark  out  1      1-cycle strobe in the first cycle sig_out=1 of each pulse
//  fall_mark  out  1      1-cycle strobe in the first cycle sig_out=0 after each pulse
//  busy       out  1      1 from the cycle after start acceptance until done
//  done       out  1      1-cycle strobe when a train completes normally
// BEHAVIOUR
//  - Reset (Rst_n=0 at a clock edge): state=IDLE, and every output is 0. Reset wins over
//    start and abort. Reset mid-train truncates immediately; no done, no fall_mark.
//  - FSM states are IDLE, HIGH, LOW and FIN. All outputs are registered.
//  - IDLE: on start=1, latch high_len, low_len and pulse_cnt into internal registers.
//    Inputs may change after that.
//    - If pulse_cnt=0, go to FIN.
//    - Otherwise go to HIGH; sig_out=1, rise_mark=1 and busy=1 in the next cycle.
//  - Zero lengths: a latched length of 0 is treated as 1. The minimum period is 2 cycles.
//  - HIGH: sig_out=1 for exactly H cycles, where H=max(high_len,1). Then go to LOW;
//    in the first LOW cycle sig_out=0 and fall_mark=1.
//  - LOW: sig_out=0 for exactly L cycles, where L=max(low_len,1). Then:
//    - If pulses remain, go to HIGH.
//    - After the last pulse, go to FIN.
//  - FIN: done=1 for one cycle, with busy still 1. Then IDLE with busy=0.
//    - start is accepted in that IDLE cycle; back-to-back trains have a 1-cycle gap.
//    - For pulse_cnt=0: start, then 1 cycle of FIN (done=1), then IDLE.
//  - start while busy=1 (including in FIN) is ignored. It is not queued.
//  - abort=1 while busy=1: the next cycle is IDLE with sig_out=0 and busy=0.
//    - No done is produced.
//    - If sig_out was 1, fall_mark=1 in that cycle, because the edge is real.
//  - abort while idle is ignored. start and abort together in IDLE: start wins.
//  - Counters: the phase counter is LEN_W bits and counts down from H-1 or L-1 to 0.
//    The pulse counter is CNT_W bits and counts down. Neither counter wraps, since both
//    reload on phase entry. Max phase = 2^LEN_W-1 cycles; max pulses = 2^CNT_W-1.
//  - Exactly one rise_mark and one fall_mark per completed pulse. The two strobes are
//    never high together.
// STRUCTURE
//  - Shared package/header `edge_pkg.vh` holds:
//    - the state encodings (IDLE=2'd0, HIGH=2'd1, LOW=2'd2, FIN=2'd3);
//    - the default widths LEN_W and CNT_W.
//    EdgeDetector benches include the same header.
//  - One sub-module, `phase_counter`: a loadable down-counter with a zero flag. It is
//    instantiated for the phase length. The pulse count stays inline.
// TESTING
//  - Reset: hold Rst_n=0 for 3 cycles with start=1.
//    -> sig_out, rise_mark, fall_mark, busy and done are all 0; no train starts.
//  - Basic train: start with high_len=3, low_len=2, pulse_cnt=2.
//    -> sig_out=1 for cycles 1-3, 0 for 4-5, 1 for 6-8, 0 for 9-10.
//    -> rise_mark at 1 and 6; fall_mark at 4 and 9; done at 11; busy=0 at 12.
//  - Degenerate command: start with high_len=0, low_len=0, pulse_cnt=1.
//    -> 1 high cycle, then 1 low cycle, then done.
//    - Separately, start with pulse_cnt=0 -> done at cycle 1 and sig_out stays 0.
//  - Abort and ignored start: start with high_len=5, pulse_cnt=3; abort in the 2nd high
//    cycle.
//    -> next cycle sig_out=0, fall_mark=1, busy=0, no done.
//    - A start pulsed mid-train is ignored.
//  - Loopback: connect sig_out to EdgeDetector and run 2^CNT_W-1 pulses with random
//    lengths.
//    -> detector rise/fall counts equal the rise_mark/fall_mark counts, at a fixed
//       latency.

Source files
------------

// File: rtl/edge_pattern_gen_pkg.sv
// Shared definitions for the edge pattern generator: FSM state encoding and
// the default phase/pulse widths.
package edge_pattern_gen_pkg;

    localparam int LEN_W_DEF = 8;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/edge_pattern_gen_phase_counter.sv
// Loadable down-counter with a zero flag, used to time each high/low phase.
module phase_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load takes priority over decrement; the count holds otherwise.
    always_ff @(posedge clk_i) begin
        // NOTE: registers take non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/edge_pattern_gen.sv
// Programmable pulse-train source with rise/fall reference strobes. A start
// command latches the high/low lengths and pulse count; the train then runs
// autonomously until done or abort.
module edge_pattern_gen
    import edge_pattern_gen_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] high_len,
    input  logic [LEN_W-1:0] low_len,
    input  logic [CNT_W-1:0] pulse_cnt,
    output logic             sig_out,
    output logic             rise_mark,
    output logic             fall_mark,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [LEN_W-1:0] high_m1_q;   // H-1, zero length already clamped to 1
    logic [LEN_W-1:0] low_m1_q;    // L-1, zero length already clamped to 1
    logic [CNT_W-1:0] pulses_q;    // pulses still to start after the current one
    logic             sig_q, rise_q, fall_q, busy_q, done_q;

    logic             ctr_load;
    logic [LEN_W-1:0] ctr_val;
    logic             ctr_dec;
    logic             ctr_zero;

    // A length of 0 behaves as 1, so the reload value is max(len,1)-1.
    function automatic logic [LEN_W-1:0] len_m1(input logic [LEN_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    // Phase counter control: reload on every phase entry, count down inside a phase.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        ctr_load = 1'b0;
        ctr_val  = '0;
        ctr_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ctr_load = 1'b1;
                    ctr_val  = len_m1(high_len);
                end
            end
            ST_HIGH: begin
                if (!abort) begin
                    if (ctr_zero) begin
                        ctr_load = 1'b1;
                        ctr_val  = low_m1_q;
                    end else begin
                        ctr_dec = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (!abort) begin
                    if (ctr_zero) begin
                        ctr_load = (pulses_q != '0);
                        ctr_val  = high_m1_q;
                    end else begin
                        ctr_dec = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    phase_counter #(.W(LEN_W)) u_phase_counter (
        .clk_i      (Clk),
        .rst_ni     (Rst_n),
        .load_i     (ctr_load),
        .load_val_i (ctr_val),
        .dec_i      (ctr_dec),
        .zero_o     (ctr_zero)
    );

    // Train FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            // NOTE: the latched command registers are reset too, so a train can
            // never start from stale lengths after reset.
            state_q   <= ST_IDLE;
            high_m1_q <= '0;
            low_m1_q  <= '0;
            pulses_q  <= '0;
            sig_q     <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        high_m1_q <= len_m1(high_len);
                        low_m1_q  <= len_m1(low_len);
                        busy_q    <= 1'b1;
                        if (pulse_cnt == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_HIGH;
                            pulses_q <= pulse_cnt - CNT_W'(1);
                            sig_q    <= 1'b1;
                            rise_q   <= 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        sig_q   <= 1'b0;
                        fall_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (ctr_zero) begin
                        state_q <= ST_LOW;
                        sig_q   <= 1'b0;
                        fall_q  <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (ctr_zero) begin
                        if (pulses_q != '0) begin
                            state_q  <= ST_HIGH;
                            pulses_q <= pulses_q - CNT_W'(1);
                            sig_q    <= 1'b1;
                            rise_q   <= 1'b1;
                        end else begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sig_out   = sig_q;
    assign rise_mark = rise_q;
    assign fall_mark = fall_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_edge_pattern_gen.sv
// Self-checking bench for edge_pattern_gen: each command's expected waveform is
// built cycle by cycle from the pulse-train rules and compared at negedges.
module tb_edge_pattern_gen;

    localparam int LEN_W = 8;
    localparam int CNT_W = 4;

    logic             Clk;
    logic             Rst_n;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] high_len;
    logic [LEN_W-1:0] low_len;
    logic [CNT_W-1:0] pulse_cnt;
    logic             sig_out, rise_mark, fall_mark, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int det_rise, det_fall, mk_rise, mk_fall;

    edge_pattern_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .start     (start),
        .abort     (abort),
        .high_len  (high_len),
        .low_len   (low_len),
        .pulse_cnt (pulse_cnt),
        .sig_out   (sig_out),
        .rise_mark (rise_mark),
        .fall_mark (fall_mark),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] obs_vec();
        return {sig_out, rise_mark, fall_mark, busy, done};
    endfunction

    // Runs one command. abort_at / stray_at are cycle numbers after acceptance
    // (cycle 1 = first busy cycle), 0 = none. Expected vector per cycle is
    // {sig_out, rise_mark, fall_mark, busy, done}.
    task automatic run_cmd(input int h, input int l, input int n,
                           input int abort_at, input int stray_at, input string name);
        logic [4:0] exp_q[$];
        logic [4:0] obs;
        logic       last_sig;
        int         hh, ll;
        hh = (h == 0) ? 1 : h;
        ll = (l == 0) ? 1 : l;
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hh; i++) exp_q.push_back({1'b1, (i == 0), 1'b0, 1'b1, 1'b0});
            for (int i = 0; i < ll; i++) exp_q.push_back({1'b0, 1'b0, (i == 0), 1'b1, 1'b0});
        end
        exp_q.push_back(5'b00011);
        if (abort_at > 0 && abort_at <= exp_q.size()) begin
            while (exp_q.size() > abort_at) void'(exp_q.pop_back());
            exp_q.push_back({1'b0, 1'b0, exp_q[abort_at-1][4], 1'b0, 1'b0});
        end

        @(negedge Clk);
        obs = obs_vec();
        n_tests++;
        if (obs !== 5'b00000) begin
            n_fail++;
            $display("FAIL %s idle-before-start: got %b want %b", name, obs, 5'b00000);
        end
        start     = 1'b1;
        abort     = 1'b0;
        high_len  = LEN_W'(h);
        low_len   = LEN_W'(l);
        pulse_cnt = CNT_W'(n);
        last_sig  = 1'b0;

        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge Clk);
            obs = obs_vec();
            n_tests++;
            if (obs !== exp_q[j]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b want %b", name, j + 1, obs, exp_q[j]);
            end
            if (sig_out && !last_sig) det_rise++;
            if (!sig_out && last_sig) det_fall++;
            last_sig = sig_out;
            if (rise_mark) mk_rise++;
            if (fall_mark) mk_fall++;
            // Scramble the command inputs to prove they were latched.
            start     = (j + 1 == stray_at);
            abort     = (j + 1 == abort_at);
            high_len  = LEN_W'($urandom);
            low_len   = LEN_W'($urandom);
            pulse_cnt = CNT_W'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n     = 1'b0;
        start     = 1'b1;
        abort     = 1'b0;
        high_len  = 8'd3;
        low_len   = 8'd2;
        pulse_cnt = 4'd2;
        repeat (3) begin
            @(negedge Clk);
            n_tests++;
            if (obs_vec() !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_hold: got %b want %b", obs_vec(), 5'b00000);
            end
        end
        start = 1'b0;
        Rst_n = 1'b1;
        @(negedge Clk);
        n_tests++;
        if (obs_vec() !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", obs_vec(), 5'b00000);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge Clk);
        start = 1'b1; high_len = 8'd4; low_len = 8'd4; pulse_cnt = 4'd3;
        @(negedge Clk);
        start = 1'b0;
        repeat (2) @(negedge Clk);
        n_tests++;
        if (busy !== 1'b1 || sig_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got busy=%b sig=%b want busy=1 sig=1", busy, sig_out);
        end
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (3) begin
            n_tests++;
            if (obs_vec() !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_mid: got %b want %b", obs_vec(), 5'b00000);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_basic();
        run_cmd(3, 2, 2, 0, 0, "basic");
    endtask

    task automatic test_degenerate();
        run_cmd(0, 0, 1, 0, 0, "zero_len");
        run_cmd(7, 9, 0, 0, 0, "zero_pulses");
    endtask

    task automatic test_abort();
        run_cmd(5, 2, 3, 2, 1, "abort_high");
        run_cmd(2, 4, 2, 4, 3, "abort_low");
        run_cmd(1, 1, 1, 3, 2, "abort_fin");
        // abort while idle must have no effect
        @(negedge Clk);
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        n_tests++;
        if (obs_vec() !== 5'b00000) begin
            n_fail++;
            $display("FAIL abort_idle: got %b want %b", obs_vec(), 5'b00000);
        end
    endtask

    task automatic test_back_to_back();
        // run_cmd starts the next train in the IDLE cycle right after FIN
        run_cmd(2, 1, 2, 0, 0, "b2b_a");
        run_cmd(1, 3, 1, 0, 0, "b2b_b");
        run_cmd(0, 0, 0, 0, 0, "b2b_c");
    endtask

    task automatic test_max_len();
        run_cmd(255, 255, 1, 0, 0, "max_len");
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            int h, l, n, busy_len, ab, st;
            h = $urandom_range(0, 6);
            l = $urandom_range(0, 6);
            n = $urandom_range(0, 5);
            busy_len = n * ((h == 0 ? 1 : h) + (l == 0 ? 1 : l)) + 1;
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, busy_len) : 0;
            st = $urandom_range(1, (ab != 0) ? ab : busy_len);
            if ($urandom_range(0, 1) == 0) st = 0;
            run_cmd(h, l, n, ab, st, $sformatf("rand%0d", k));
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end
    endtask

    task automatic test_loopback();
        det_rise = 0; det_fall = 0; mk_rise = 0; mk_fall = 0;
        run_cmd($urandom_range(0, 6), $urandom_range(0, 6), 15, 0, 0, "loopback");
        n_tests++;
        if (det_rise !== mk_rise || mk_rise !== 15) begin
            n_fail++;
            $display("FAIL loopback_rise: detected %0d marks %0d want 15", det_rise, mk_rise);
        end
        n_tests++;
        if (det_fall !== mk_fall || mk_fall !== 15) begin
            n_fail++;
            $display("FAIL loopback_fall: detected %0d marks %0d want 15", det_fall, mk_fall);
        end
    endtask

    initial begin
        det_rise = 0; det_fall = 0; mk_rise = 0; mk_fall = 0;
        test_reset();
        test_basic();
        test_degenerate();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_max_len();
        test_random();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
